ram_arb: RTL and testbench

RAM_ARB -- requirements
Module: ram_arb

---
 rtl/ram_arb.sv | 93 +++++++++
 tb/tb_ram_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb.sv
// ram_arb: two-requester RAM arbiter with independent round-robin write/read ports and read-return tracking
module ram_arb #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_wr_enb,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enb,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  logic                  wr_ptr, rd_ptr;
  logic [RD_LAT-1:0]     pv, pid;
  logic                  w0, w1, r0, r1;
  logic                  wr_any, rd_any, wr_id, rd_id, rd_ok;
  logic [ADDR_WIDTH-1:0] wa, ra;

  // Per-port arbitration: pointer breaks ties, a read yields to a same-address write
  always_comb begin
    w0     = rst & m0_req & m0_we;
    w1     = rst & m1_req & m1_we;
    r0     = rst & m0_req & ~m0_we;
    r1     = rst & m1_req & ~m1_we;
    wr_any = w0 | w1;
    rd_any = r0 | r1;
    wr_id  = (w0 & w1) ? wr_ptr : w1;
    rd_id  = (r0 & r1) ? rd_ptr : r1;
    wa     = wr_id ? m1_addr : m0_addr;
    ra     = rd_id ? m1_addr : m0_addr;
    rd_ok  = rd_any & ~(wr_any & (wa == ra));
  end

  // Grants, RAM port drive and read-return demux; idle fields are forced to zero
  always_comb begin
    m0_gnt      = (wr_any & ~wr_id) | (rd_ok & ~rd_id);
    m1_gnt      = (wr_any & wr_id) | (rd_ok & rd_id);
    ram_wr_enb  = wr_any;
    ram_wr_addr = wr_any ? wa : '0;
    ram_wr_data = wr_any ? (wr_id ? m1_wdata : m0_wdata) : '0;
    ram_rd_enb  = rd_ok;
    ram_rd_addr = rd_ok ? ra : '0;
    m0_rvalid   = pv[RD_LAT-1] & ~pid[RD_LAT-1];
    m1_rvalid   = pv[RD_LAT-1] & pid[RD_LAT-1];
    m0_rdata    = m0_rvalid ? ram_rd_data : '0;
    m1_rdata    = m1_rvalid ? ram_rd_data : '0;
  end

  // Round-robin pointers: hand priority to the other requester after each grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr_any) wr_ptr <= ~wr_id;
      if (rd_ok)  rd_ptr <= ~rd_id;
    end
  end

  // Read-return pipeline of {valid, id}, one stage per cycle of RAM read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv  <= '0;
      pid <= '0;
    end else begin
      pv[0]  <= rd_ok;
      pid[0] <= rd_id;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: directed self-checking bench for ram_arb with a 2-cycle RAM model
module tb_ram_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [3:0] m0_addr = '0, m1_addr = '0;
  logic [7:0] m0_wdata = '0, m1_wdata = '0;
  logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata;
  logic       ram_wr_enb, ram_rd_enb;
  logic [3:0] ram_wr_addr, ram_rd_addr;
  logic [7:0] ram_wr_data, ram_rd_data;
  logic [7:0] mem [16];
  logic [7:0] d1, d2;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  ram_arb #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wr_enb(ram_wr_enb), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_enb(ram_rd_enb), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  // RAM with two-cycle read latency
  always @(posedge clk) begin
    if (ram_wr_enb) mem[ram_wr_addr] <= ram_wr_data;
    d1 <= mem[ram_rd_addr];
    d2 <= d1;
  end
  assign ram_rd_data = d2;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [3:0] addr, input logic [7:0] wd);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [3:0] addr, input logic [7:0] wd);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd;
  endtask

  task automatic test_reset();
    set_m0(1, 1, 4'h3, 8'hA5);
    set_m1(1, 0, 4'h6, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wr_enb, ram_rd_enb} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags got %b exp 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wr_enb, ram_rd_enb});
    end
    n_cmp++;
    if ({ram_wr_addr, ram_rd_addr, ram_wr_data, m0_rdata, m1_rdata} !== 32'h0) begin
      n_err++; $display("FAIL reset_buses got %h exp 0", {ram_wr_addr, ram_rd_addr, ram_wr_data, m0_rdata, m1_rdata});
    end
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_single_write();
    set_m0(1, 1, 4'h3, 8'hA5);
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, ram_wr_enb, ram_rd_enb} !== 4'b1010) begin
      n_err++; $display("FAIL single_write_flags got %b exp 1010", {m0_gnt, m1_gnt, ram_wr_enb, ram_rd_enb});
    end
    n_cmp++;
    if ({ram_wr_addr, ram_wr_data} !== 12'h3A5) begin
      n_err++; $display("FAIL single_write_bus got %h exp 3a5", {ram_wr_addr, ram_wr_data});
    end
    cyc();
    set_m0(1, 1, 4'h1, 8'h11);
    set_m1(1, 1, 4'h2, 8'h22);
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, ram_wr_addr, ram_wr_data} !== 14'b01_0010_00100010) begin
      n_err++; $display("FAIL wr_ptr_after_m0 got gnt=%b addr=%h data=%h exp gnt=01 addr=2 data=22", {m0_gnt, m1_gnt}, ram_wr_addr, ram_wr_data);
    end
    cyc();
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || ram_wr_data !== ((i % 2 == 0) ? 8'h11 : 8'h22)) begin
        n_err++; $display("FAIL alternate[%0d] got gnt=%b data=%h exp gnt=%b data=%h", i, {m0_gnt, m1_gnt}, ram_wr_data,
                          (i % 2 == 0) ? 2'b10 : 2'b01, (i % 2 == 0) ? 8'h11 : 8'h22);
      end
      cyc();
    end
    set_m0(0, 0, 0, 0);
    set_m1(1, 1, 4'h4, 8'h44);
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, ram_wr_enb, ram_wr_addr} !== 7'b011_0100) begin
      n_err++; $display("FAIL lone_m1_write got gnt=%b enb=%b addr=%h exp gnt=01 enb=1 addr=4", {m0_gnt, m1_gnt}, ram_wr_enb, ram_wr_addr);
    end
    cyc();
    set_m1(0, 0, 0, 0);
  endtask

  task automatic test_collision();
    set_m0(1, 1, 4'h5, 8'h5C);
    set_m1(1, 0, 4'h5, 8'h00);
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, ram_wr_enb, ram_rd_enb, ram_rd_addr} !== 8'b1010_0000) begin
      n_err++; $display("FAIL collision_cycle got gnt=%b wr=%b rd=%b rd_addr=%h exp gnt=10 wr=1 rd=0 rd_addr=0",
                        {m0_gnt, m1_gnt}, ram_wr_enb, ram_rd_enb, ram_rd_addr);
    end
    cyc();
    set_m0(0, 0, 0, 0);
    #1;
    n_cmp++;
    if ({m1_gnt, ram_rd_enb, ram_rd_addr, m1_rvalid} !== 7'b11_0101_0) begin
      n_err++; $display("FAIL collision_retry got gnt=%b rd=%b rd_addr=%h rvalid=%b exp gnt=1 rd=1 rd_addr=5 rvalid=0",
                        m1_gnt, ram_rd_enb, ram_rd_addr, m1_rvalid);
    end
    cyc();
    set_m1(0, 0, 0, 0);
    #1;
    n_cmp++;
    if (m1_rvalid !== 1'b0) begin
      n_err++; $display("FAIL collision_early_rvalid got %b exp 0", m1_rvalid);
    end
    cyc();
    #1;
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m1_rdata} !== 10'b01_01011100) begin
      n_err++; $display("FAIL collision_return got rvalid=%b rdata=%h exp rvalid=01 rdata=5c", {m0_rvalid, m1_rvalid}, m1_rdata);
    end
    cyc();
    #1;
    n_cmp++;
    if ({m1_rvalid, m1_rdata} !== 9'h0) begin
      n_err++; $display("FAIL collision_after got rvalid=%b rdata=%h exp 0/00", m1_rvalid, m1_rdata);
    end
  endtask

  task automatic test_parallel();
    set_m0(1, 1, 4'h7, 8'h77);
    set_m1(1, 0, 4'h3, 8'h00);
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, ram_wr_enb, ram_rd_enb, ram_wr_addr, ram_rd_addr} !== 12'b1111_0111_0011) begin
      n_err++; $display("FAIL parallel_grants got gnt=%b wr=%b rd=%b wa=%h ra=%h exp gnt=11 wr=1 rd=1 wa=7 ra=3",
                        {m0_gnt, m1_gnt}, ram_wr_enb, ram_rd_enb, ram_wr_addr, ram_rd_addr);
    end
    cyc();
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    cyc();
    #1;
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m1_rdata} !== 10'b01_10100101) begin
      n_err++; $display("FAIL parallel_return got rvalid=%b rdata=%h exp rvalid=01 rdata=a5", {m0_rvalid, m1_rvalid}, m1_rdata);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ed [6];
    logic       ev;
    ed = '{8'h00, 8'h00, 8'h11, 8'h22, 8'hA5, 8'h00};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) set_m0(1, 0, 4'(i + 1), 8'h00);
      else set_m0(0, 0, 0, 0);
      #1;
      ev = (i >= 2 && i < 5);
      if (i < 3) begin
        n_cmp++;
        if (m0_gnt !== 1'b1) begin
          n_err++; $display("FAIL b2b_gnt[%0d] got %b exp 1", i, m0_gnt);
        end
      end
      n_cmp++;
      if (m0_rvalid !== ev || m0_rdata !== ed[i] || m1_rvalid !== 1'b0) begin
        n_err++; $display("FAIL b2b_return[%0d] got m0_rvalid=%b m0_rdata=%h m1_rvalid=%b exp %b/%h/0",
                          i, m0_rvalid, m0_rdata, m1_rvalid, ev, ed[i]);
      end
      cyc();
    end
  endtask

  task automatic test_reset_flight();
    set_m0(1, 0, 4'h3, 8'h00);
    #1;
    n_cmp++;
    if (m0_gnt !== 1'b1) begin
      n_err++; $display("FAIL flight_gnt got %b exp 1", m0_gnt);
    end
    cyc();
    set_m1(1, 1, 4'h9, 8'h99);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wr_enb, ram_rd_enb, ram_wr_addr, ram_rd_addr, ram_wr_data} !== 22'h0) begin
      n_err++; $display("FAIL flight_reset_outputs got gnt=%b rv=%b wr=%b rd=%b wa=%h ra=%h wd=%h exp all 0",
                        {m0_gnt, m1_gnt}, {m0_rvalid, m1_rvalid}, ram_wr_enb, ram_rd_enb, ram_wr_addr, ram_rd_addr, ram_wr_data);
    end
    cyc();
    #1;
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 18'h0) begin
      n_err++; $display("FAIL flight_discard_in_reset got rvalid=%b exp 00", {m0_rvalid, m1_rvalid});
    end
    rst = 1'b1;
    set_m0(1, 1, 4'h8, 8'h80);
    set_m1(1, 1, 4'h9, 8'h90);
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, ram_wr_addr, m0_rvalid, m1_rvalid} !== 8'b10_1000_00) begin
      n_err++; $display("FAIL post_reset_wr got gnt=%b wa=%h rv=%b exp gnt=10 wa=8 rv=00", {m0_gnt, m1_gnt}, ram_wr_addr, {m0_rvalid, m1_rvalid});
    end
    cyc();
    set_m0(1, 0, 4'h8, 8'h00);
    set_m1(1, 0, 4'h9, 8'h00);
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, ram_rd_addr, m0_rvalid, m1_rvalid} !== 8'b10_1000_00) begin
      n_err++; $display("FAIL post_reset_rd got gnt=%b ra=%h rv=%b exp gnt=10 ra=8 rv=00", {m0_gnt, m1_gnt}, ram_rd_addr, {m0_rvalid, m1_rvalid});
    end
    cyc();
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    #1;
    n_cmp++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      n_err++; $display("FAIL post_reset_early got rvalid=%b exp 00", {m0_rvalid, m1_rvalid});
    end
    cyc();
    #1;
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== 10'b10_10000000) begin
      n_err++; $display("FAIL post_reset_return got rvalid=%b rdata=%h exp rvalid=10 rdata=80", {m0_rvalid, m1_rvalid}, m0_rdata);
    end
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_single_write();
    test_alternate();
    test_collision();
    test_parallel();
    test_back_to_back();
    test_reset_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
